// File: rtl/key_byte_receiver_if.sv
// Key-byte receiver bus: keyboard capture inputs, read handshake and status.
// The master drives keys and reads; the slave is the receiver.
interface key_byte_receiver_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] savedByte;
  logic             keyReady;
  logic [WIDTH-1:0] rdByte;
  logic             rdValid;
  logic             rdReady;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             clearOverflow;

  modport master (
    output savedByte, keyReady, rdReady, clearOverflow,
    input  rdByte, rdValid, count, overflow
  );

  modport slave (
    input  savedByte, keyReady, rdReady, clearOverflow,
    output rdByte, rdValid, count, overflow
  );
endinterface

// File: rtl/key_byte_receiver.sv
// Captures debounced key bytes on keyReady rising edges into a
// first-word-fall-through FIFO read over a valid/ready handshake.
module key_byte_receiver #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input logic                  clk,
  input logic                  RST,
  key_byte_receiver_if.slave   bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wrPtr;
  logic [PW-1:0]    rdPtr;
  logic [CW-1:0]    countQ;
  logic             full;
  logic             rdValidQ;
  logic [WIDTH-1:0] rdByteQ;
  logic             overflowQ;
  logic             keyReadyPrev;

  logic             push;
  logic             pop;
  logic             pushOk;
  logic             drop;
  logic [PW-1:0]    nextRdPtr;
  logic [CW-1:0]    nextCount;
  logic [WIDTH-1:0] nextHead;

  // Handshake decode and next head-of-FIFO value for the registered rdByte
  always_comb begin
    push      = bus.keyReady & ~keyReadyPrev & (bus.savedByte != '0);
    pop       = rdValidQ & bus.rdReady;
    pushOk    = push & (~full | pop);
    drop      = push & full & ~pop;
    nextRdPtr = pop ? rdPtr + PW'(1) : rdPtr;
    nextCount = countQ + CW'(pushOk) - CW'(pop);
    nextHead  = '0;
    if (nextCount != '0) begin
      // Head is the byte being written this cycle when the FIFO drains to it
      if (pushOk && (nextRdPtr == wrPtr)) begin
        nextHead = bus.savedByte;
      end else begin
        nextHead = mem[nextRdPtr];
      end
    end
  end

  // Storage array; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (pushOk) begin
      mem[wrPtr] <= bus.savedByte;
    end
  end

  // Pointers, occupancy, flags and registered read port
  always_ff @(posedge clk) begin
    if (RST) begin
      wrPtr        <= '0;
      rdPtr        <= '0;
      countQ       <= '0;
      full         <= 1'b0;
      rdValidQ     <= 1'b0;
      rdByteQ      <= '0;
      overflowQ    <= 1'b0;
      keyReadyPrev <= 1'b1;
    end else begin
      keyReadyPrev <= bus.keyReady;
      if (pushOk) begin
        wrPtr <= wrPtr + PW'(1);
      end
      rdPtr    <= nextRdPtr;
      countQ   <= nextCount;
      full     <= (nextCount == CW'(DEPTH));
      rdValidQ <= (nextCount != '0);
      rdByteQ  <= nextHead;
      if (drop) begin
        overflowQ <= 1'b1;
      end else if (bus.clearOverflow) begin
        overflowQ <= 1'b0;
      end
    end
  end

  assign bus.rdByte   = rdByteQ;
  assign bus.rdValid  = rdValidQ;
  assign bus.count    = countQ;
  assign bus.overflow = overflowQ;
endmodule

// File: tb/tb_key_byte_receiver.sv
// Directed self-checking bench for key_byte_receiver (WIDTH=8, DEPTH=8).
module tb_key_byte_receiver;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  key_byte_receiver_if #(.WIDTH(8), .DEPTH(8)) kbIf ();

  key_byte_receiver #(.WIDTH(8), .DEPTH(8)) dut (
    .clk (clk),
    .RST (rst),
    .bus (kbIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; inputs change and outputs are sampled 1ns after posedge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle keyReady strobe followed by one low cycle
  task automatic pulse(input logic [7:0] b);
    kbIf.savedByte = b;
    kbIf.keyReady  = 1'b1;
    tick();
    kbIf.keyReady  = 1'b0;
    tick();
  endtask

  task automatic popOne();
    kbIf.rdReady = 1'b1;
    tick();
    kbIf.rdReady = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks += 4;
    if (kbIf.count !== 4'd0) begin failures++; $display("FAIL reset_count got %0d want 0", kbIf.count); end
    if (kbIf.rdValid !== 1'b0) begin failures++; $display("FAIL reset_valid got %b want 0", kbIf.rdValid); end
    if (kbIf.rdByte !== 8'h00) begin failures++; $display("FAIL reset_byte got %h want 00", kbIf.rdByte); end
    if (kbIf.overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got %b want 0", kbIf.overflow); end
    tick();
  endtask

  task automatic test_single();
    kbIf.savedByte = 8'h48;
    kbIf.keyReady  = 1'b1;
    tick();
    kbIf.keyReady  = 1'b0;
    checks += 3;
    if (kbIf.rdValid !== 1'b1) begin failures++; $display("FAIL single_valid got %b want 1", kbIf.rdValid); end
    if (kbIf.rdByte !== 8'h48) begin failures++; $display("FAIL single_byte got %h want 48", kbIf.rdByte); end
    if (kbIf.count !== 4'd1) begin failures++; $display("FAIL single_count got %0d want 1", kbIf.count); end
    popOne();
    checks += 3;
    if (kbIf.rdValid !== 1'b0) begin failures++; $display("FAIL single_pop_valid got %b want 0", kbIf.rdValid); end
    if (kbIf.count !== 4'd0) begin failures++; $display("FAIL single_pop_count got %0d want 0", kbIf.count); end
    if (kbIf.rdByte !== 8'h00) begin failures++; $display("FAIL single_pop_byte got %h want 00", kbIf.rdByte); end
    popOne();
    checks += 1;
    if (kbIf.count !== 4'd0) begin failures++; $display("FAIL empty_pop_count got %0d want 0", kbIf.count); end
  endtask

  task automatic test_held();
    kbIf.savedByte = 8'h41;
    kbIf.keyReady  = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    kbIf.keyReady = 1'b0;
    tick();
    checks += 2;
    if (kbIf.count !== 4'd1) begin failures++; $display("FAIL held_count got %0d want 1", kbIf.count); end
    if (kbIf.rdByte !== 8'h41) begin failures++; $display("FAIL held_byte got %h want 41", kbIf.rdByte); end
    popOne();
    checks += 1;
    if (kbIf.count !== 4'd0) begin failures++; $display("FAIL held_drain got %0d want 0", kbIf.count); end
  endtask

  task automatic test_overflow();
    logic [7:0] exp;
    for (int i = 0; i < 9; i++) pulse(8'h31 + 8'(i));
    checks += 2;
    if (kbIf.count !== 4'd8) begin failures++; $display("FAIL ovf_count got %0d want 8", kbIf.count); end
    if (kbIf.overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got %b want 1", kbIf.overflow); end
    for (int i = 0; i < 8; i++) begin
      exp = 8'h31 + 8'(i);
      checks++;
      if (kbIf.rdByte !== exp) begin failures++; $display("FAIL ovf_order[%0d] got %h want %h", i, kbIf.rdByte, exp); end
      popOne();
    end
    checks += 3;
    if (kbIf.rdValid !== 1'b0) begin failures++; $display("FAIL ovf_drained got %b want 0", kbIf.rdValid); end
    if (kbIf.overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got %b want 1", kbIf.overflow); end
    kbIf.clearOverflow = 1'b1;
    tick();
    kbIf.clearOverflow = 1'b0;
    if (kbIf.overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got %b want 0", kbIf.overflow); end
  endtask

  task automatic test_push_pop_full();
    logic [7:0] exp;
    for (int i = 0; i < 8; i++) pulse(8'h61 + 8'(i));
    kbIf.savedByte = 8'h5A;
    kbIf.keyReady  = 1'b1;
    kbIf.rdReady   = 1'b1;
    tick();
    kbIf.keyReady  = 1'b0;
    kbIf.rdReady   = 1'b0;
    checks += 3;
    if (kbIf.count !== 4'd8) begin failures++; $display("FAIL full_pp_count got %0d want 8", kbIf.count); end
    if (kbIf.overflow !== 1'b0) begin failures++; $display("FAIL full_pp_ovf got %b want 0", kbIf.overflow); end
    if (kbIf.rdByte !== 8'h62) begin failures++; $display("FAIL full_pp_head got %h want 62", kbIf.rdByte); end
    for (int i = 0; i < 8; i++) begin
      exp = (i == 7) ? 8'h5A : 8'h62 + 8'(i);
      checks++;
      if (kbIf.rdByte !== exp) begin failures++; $display("FAIL full_pp_order[%0d] got %h want %h", i, kbIf.rdByte, exp); end
      popOne();
    end
    checks += 1;
    if (kbIf.count !== 4'd0) begin failures++; $display("FAIL full_pp_drain got %0d want 0", kbIf.count); end
  endtask

  task automatic test_wrap();
    logic [7:0] exp;
    for (int i = 0; i < 12; i++) begin
      exp = 8'h70 + 8'(i);
      pulse(exp);
      pulse(8'h00);
      checks += 2;
      if (kbIf.count !== 4'd1) begin failures++; $display("FAIL wrap_count[%0d] got %0d want 1", i, kbIf.count); end
      if (kbIf.rdByte !== exp) begin failures++; $display("FAIL wrap_byte[%0d] got %h want %h", i, kbIf.rdByte, exp); end
      popOne();
    end
    checks += 1;
    if (kbIf.rdValid !== 1'b0) begin failures++; $display("FAIL wrap_end got %b want 0", kbIf.rdValid); end
  endtask

  task automatic test_empty_push_pop();
    kbIf.savedByte = 8'h2C;
    kbIf.keyReady  = 1'b1;
    kbIf.rdReady   = 1'b1;
    tick();
    kbIf.keyReady  = 1'b0;
    kbIf.rdReady   = 1'b0;
    checks += 2;
    if (kbIf.count !== 4'd1) begin failures++; $display("FAIL empty_pp_count got %0d want 1", kbIf.count); end
    if (kbIf.rdByte !== 8'h2C) begin failures++; $display("FAIL empty_pp_byte got %h want 2c", kbIf.rdByte); end
    tick();
    popOne();
  endtask

  task automatic test_clear_vs_drop();
    for (int i = 0; i < 8; i++) pulse(8'h81 + 8'(i));
    pulse(8'h00);
    checks += 1;
    if (kbIf.overflow !== 1'b0) begin failures++; $display("FAIL zero_full_ovf got %b want 0", kbIf.overflow); end
    kbIf.savedByte     = 8'h11;
    kbIf.keyReady      = 1'b1;
    kbIf.clearOverflow = 1'b1;
    tick();
    kbIf.keyReady      = 1'b0;
    kbIf.clearOverflow = 1'b0;
    checks += 2;
    if (kbIf.overflow !== 1'b1) begin failures++; $display("FAIL set_wins got %b want 1", kbIf.overflow); end
    if (kbIf.count !== 4'd8) begin failures++; $display("FAIL drop_count got %0d want 8", kbIf.count); end
    tick();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) popOne();
    checks += 1;
    if (kbIf.count !== 4'd5) begin failures++; $display("FAIL mid_pre_count got %0d want 5", kbIf.count); end
    kbIf.savedByte = 8'h22;
    kbIf.keyReady  = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks += 3;
    if (kbIf.count !== 4'd0) begin failures++; $display("FAIL mid_count got %0d want 0", kbIf.count); end
    if (kbIf.rdValid !== 1'b0) begin failures++; $display("FAIL mid_valid got %b want 0", kbIf.rdValid); end
    if (kbIf.overflow !== 1'b0) begin failures++; $display("FAIL mid_ovf got %b want 0", kbIf.overflow); end
    for (int i = 0; i < 3; i++) tick();
    checks += 1;
    if (kbIf.count !== 4'd0) begin failures++; $display("FAIL mid_held_count got %0d want 0", kbIf.count); end
    kbIf.keyReady = 1'b0;
    tick();
    kbIf.keyReady = 1'b1;
    tick();
    kbIf.keyReady = 1'b0;
    checks += 2;
    if (kbIf.count !== 4'd1) begin failures++; $display("FAIL mid_rerise_count got %0d want 1", kbIf.count); end
    if (kbIf.rdByte !== 8'h22) begin failures++; $display("FAIL mid_rerise_byte got %h want 22", kbIf.rdByte); end
  endtask

  initial begin
    checks             = 0;
    failures           = 0;
    rst                = 1'b1;
    kbIf.savedByte     = 8'h00;
    kbIf.keyReady      = 1'b0;
    kbIf.rdReady       = 1'b0;
    kbIf.clearOverflow = 1'b0;
    test_reset();
    test_single();
    test_held();
    test_overflow();
    test_push_pop_full();
    test_wrap();
    test_empty_push_pop();
    test_clear_vs_drop();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
